// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command-frame parser:
//   - state_t        : frame decoder states
//   - ERR_*          : err_code values reported with cmd_err
//   - DEFAULT_HEADER : default start-of-frame byte
//   - csum_step      : one step of the running XOR checksum
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

    // Fold one received byte into the running XOR checksum.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// ---------------------------------------------------------------------------
// uart_cmd_buf
// MAX_LEN x 8-bit payload staging buffer with synchronous clear, indexed
// byte write and a flat read vector (byte i at [8i+7:8i]).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clr       : clear every byte to zero (wins over i_wr)
//   i_wr        : write i_data into byte i_idx
//   i_idx       : byte index of the write
//   i_data      : byte to write
//   o_data      : flat contents of the buffer
// ---------------------------------------------------------------------------
module uart_cmd_buf
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int IW      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_wr,
    input  logic [IW-1:0]          i_idx,
    input  logic [7:0]             i_data,
    output logic [8*MAX_LEN-1:0]   o_data
);

    logic [8*MAX_LEN-1:0] r_mem;

    // Staging storage: clear or single indexed byte write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else if (i_clr) begin
            r_mem <= '0;
        end else if (i_wr) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i_idx == IW'(i)) begin
                    r_mem[8*i +: 8] <= i_data;
                end
            end
        end
    end

    assign o_data = r_mem;

endmodule

// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
// Decodes frames  HEADER, code, len, payload[len], xor-checksum  from the
// UART receiver byte stream and presents each good frame as a registered,
// one-cycle cmd_valid record; malformed frames give a one-cycle cmd_err
// with err_code (1 checksum, 2 length, 3 timeout).
// Optional feature macro: UART_CMD_TIMEOUT_EN (inter-byte timeout, error 3).
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   pi_data, pi_flag   : received byte and its one-cycle strobe
//   cmd_code/len/payload : last good frame (change only with cmd_valid)
//   cmd_valid          : new good frame pulse
//   cmd_err, err_code  : dropped-frame pulse, reason (held until next error)
//   busy               : decoder is inside a frame
// ---------------------------------------------------------------------------
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int          CLK_FREQ      = 100_000_000,
    parameter int          UART_BPS      = 115200,
    parameter int          MAX_LEN       = 8,
    parameter logic [7:0]  HEADER        = DEFAULT_HEADER,
    parameter int          TIMEOUT_BYTES = 4,
    localparam int         LW            = $clog2(MAX_LEN + 1)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [7:0]             pi_data,
    input  logic                   pi_flag,
    output logic [7:0]             cmd_code,
    output logic [LW-1:0]          cmd_len,
    output logic [8*MAX_LEN-1:0]   cmd_payload,
    output logic                   cmd_valid,
    output logic                   cmd_err,
    output logic [1:0]             err_code,
    output logic                   busy
);

    localparam int         TIMEOUT_CYC = TIMEOUT_BYTES * 10 * (CLK_FREQ / UART_BPS);
    localparam logic [7:0] MAX_LEN_B   = 8'(MAX_LEN);

    // Reject configurations the length field or timeout counter cannot represent.
    if (MAX_LEN < 1 || MAX_LEN > 15 || TIMEOUT_CYC < 2) begin : g_cfg_check
        $error("uart_cmd_parser: unsupported MAX_LEN or timeout configuration");
    end

    state_t                r_state;
    state_t                w_next_state;
    logic [7:0]            r_code;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         r_idx;
    logic [7:0]            r_csum;
    logic [7:0]            w_csum_next;
    logic                  w_valid;
    logic                  w_err;
    logic [1:0]            w_err_code;
    logic                  w_buf_clr;
    logic                  w_buf_wr;
    logic                  w_tmo;
    logic [8*MAX_LEN-1:0]  w_buf_data;

    uart_cmd_buf #(
        .MAX_LEN (MAX_LEN),
        .IW      (LW)
    ) u_buf (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .i_clr  (w_buf_clr),
        .i_wr   (w_buf_wr),
        .i_idx  (r_idx),
        .i_data (pi_data),
        .o_data (w_buf_data)
    );

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] r_tmo_cnt;

    // A byte in the same cycle as the terminal count wins over the timeout.
    assign w_tmo = (r_state != ST_IDLE) && !pi_flag &&
                   (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // Inter-byte timer: restarts on every byte, runs only inside a frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tmo_cnt <= '0;
        end else if (pi_flag || (r_state == ST_IDLE) || w_tmo) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the frame-complete / frame-dropped strobes.
    always_comb begin
        w_next_state = r_state;
        w_valid      = 1'b0;
        w_err        = 1'b0;
        w_err_code   = ERR_NONE;
        w_buf_clr    = 1'b0;
        w_buf_wr     = 1'b0;
        w_csum_next  = csum_step(r_csum, pi_data);
        if (pi_flag) begin
            case (r_state)
                ST_IDLE: begin
                    if (pi_data == HEADER) begin
                        w_next_state = ST_CMD;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    w_next_state = ST_LEN;
                end
                ST_LEN: begin
                    // Clearing on every length byte keeps unused output bytes
                    // zero even for zero-length frames.
                    w_buf_clr = 1'b1;
                    if (pi_data > MAX_LEN_B) begin
                        w_next_state = ST_IDLE;
                        w_err        = 1'b1;
                        w_err_code   = ERR_LEN;
                    end else if (pi_data == 8'd0) begin
                        w_next_state = ST_CHECK;
                    end else begin
                        w_next_state = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    w_buf_wr = 1'b1;
                    if (r_idx == (r_len - LW'(1))) begin
                        w_next_state = ST_CHECK;
                    end else begin
                        w_next_state = ST_PAYLOAD;
                    end
                end
                ST_CHECK: begin
                    w_next_state = ST_IDLE;
                    if (pi_data == r_csum) begin
                        w_valid = 1'b1;
                    end else begin
                        w_err      = 1'b1;
                        w_err_code = ERR_CSUM;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end else if (w_tmo) begin
            w_next_state = ST_IDLE;
            w_err        = 1'b1;
            w_err_code   = ERR_TMO;
        end else begin
            w_next_state = r_state;
        end
    end

    // Frame working registers: code, length, payload index, checksum.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_code <= 8'd0;
            r_len  <= '0;
            r_idx  <= '0;
            r_csum <= 8'd0;
        end else if (pi_flag) begin
            case (r_state)
                ST_CMD: begin
                    r_code <= pi_data;
                    r_csum <= pi_data;
                end
                ST_LEN: begin
                    r_len  <= pi_data[LW-1:0];
                    r_idx  <= '0;
                    r_csum <= w_csum_next;
                end
                ST_PAYLOAD: begin
                    r_idx  <= r_idx + LW'(1);
                    r_csum <= w_csum_next;
                end
                default: begin
                    r_csum <= r_csum;
                end
            endcase
        end
    end

    // Registered outputs; the command record moves only on a good frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cmd_code    <= 8'd0;
            cmd_len     <= '0;
            cmd_payload <= '0;
            cmd_valid   <= 1'b0;
            cmd_err     <= 1'b0;
            err_code    <= ERR_NONE;
            busy        <= 1'b0;
        end else begin
            cmd_valid <= w_valid;
            cmd_err   <= w_err;
            busy      <= (w_next_state != ST_IDLE);
            if (w_valid) begin
                cmd_code    <= r_code;
                cmd_len     <= r_len;
                cmd_payload <= w_buf_data;
            end
            if (w_err) begin
                err_code <= w_err_code;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_parser
// Directed testbench for uart_cmd_parser (default parameters, MAX_LEN = 8).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_cmd_parser;

    localparam int TC = 4 * 10 * (100_000_000 / 115200);

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  pi_data = 8'd0;
    logic        pi_flag = 1'b0;
    logic [7:0]  cmd_code;
    logic [3:0]  cmd_len;
    logic [63:0] cmd_payload;
    logic        cmd_valid;
    logic        cmd_err;
    logic [1:0]  err_code;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;
    int err_seen = 0;
    int e0;

    uart_cmd_parser dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .pi_data     (pi_data),
        .pi_flag     (pi_flag),
        .cmd_code    (cmd_code),
        .cmd_len     (cmd_len),
        .cmd_payload (cmd_payload),
        .cmd_valid   (cmd_valid),
        .cmd_err     (cmd_err),
        .err_code    (err_code),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (cmd_err) err_seen <= err_seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        pi_data = b;
        pi_flag = 1'b1;
        @(negedge sys_clk);
        pi_flag = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        // Reset values
        idle(3);
        check("rst_code", 64'(cmd_code), 64'h0);
        check("rst_len", 64'(cmd_len), 64'h0);
        check("rst_payload", cmd_payload, 64'h0);
        check("rst_valid", 64'(cmd_valid), 64'h0);
        check("rst_err", 64'(cmd_err), 64'h0);
        check("rst_errcode", 64'(err_code), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        sys_rst_n = 1'b1;
        idle(2);

        // Good frame: csum = 01^02^10^20 = 33
        send(8'hAA);
        check("g1_busy_hdr", 64'(busy), 64'h1);
        send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h33);
        check("g1_valid", 64'(cmd_valid), 64'h1);
        check("g1_code", 64'(cmd_code), 64'h01);
        check("g1_len", 64'(cmd_len), 64'h2);
        check("g1_payload", cmd_payload, 64'h2010);
        check("g1_err", 64'(cmd_err), 64'h0);
        check("g1_busy_end", 64'(busy), 64'h0);
        idle(1);
        check("g1_valid_1cyc", 64'(cmd_valid), 64'h0);

        // Bad checksum: outputs hold the previous frame
        send(8'hAA); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h34);
        check("cs_err", 64'(cmd_err), 64'h1);
        check("cs_code", 64'(err_code), 64'h1);
        check("cs_valid", 64'(cmd_valid), 64'h0);
        check("cs_hold_code", 64'(cmd_code), 64'h01);
        check("cs_hold_payload", cmd_payload, 64'h2010);
        idle(1);
        check("cs_err_1cyc", 64'(cmd_err), 64'h0);
        check("cs_errcode_held", 64'(err_code), 64'h1);

        // Length error (9 > MAX_LEN) then zero-length frame: csum = 05^00 = 05
        send(8'hAA); send(8'h07); send(8'h09);
        check("len_err", 64'(cmd_err), 64'h1);
        check("len_code", 64'(err_code), 64'h2);
        check("len_busy", 64'(busy), 64'h0);
        send(8'hAA); send(8'h05); send(8'h00); send(8'h05);
        check("z_valid", 64'(cmd_valid), 64'h1);
        check("z_code", 64'(cmd_code), 64'h05);
        check("z_len", 64'(cmd_len), 64'h0);
        check("z_payload", cmd_payload, 64'h0);
        check("z_errcode_held", 64'(err_code), 64'h2);

        // Maximum length: csum = 10^08^(01^..^08 = 08) = 10
        send(8'hAA); send(8'h10); send(8'h08);
        for (int i = 1; i <= 8; i++) send(8'(i));
        send(8'h10);
        check("max_valid", 64'(cmd_valid), 64'h1);
        check("max_len", 64'(cmd_len), 64'h8);
        check("max_payload", cmd_payload, 64'h0807060504030201);

        // Header directly after check byte (back-to-back strobes)
        send(8'hAA); send(8'h02); send(8'h00); send(8'h02);
        check("b2b_valid1", 64'(cmd_valid), 64'h1);
        check("b2b_code1", 64'(cmd_code), 64'h02);
        send(8'hAA); send(8'h04); send(8'h00); send(8'h04);
        check("b2b_valid2", 64'(cmd_valid), 64'h1);
        check("b2b_code2", 64'(cmd_code), 64'h04);

        // Noise and embedded header: csum = AA^01^AA = 01
        send(8'h55); send(8'hAA); send(8'hAA); send(8'h01); send(8'hAA); send(8'h01);
        check("emb_valid", 64'(cmd_valid), 64'h1);
        check("emb_code", 64'(cmd_code), 64'hAA);
        check("emb_len", 64'(cmd_len), 64'h1);
        check("emb_payload", cmd_payload, 64'hAA);

        // Reset mid-frame
        send(8'hAA); send(8'h01);
        e0 = err_seen;
        sys_rst_n = 1'b0;
        #1;
        check("mr_code", 64'(cmd_code), 64'h0);
        check("mr_len", 64'(cmd_len), 64'h0);
        check("mr_payload", cmd_payload, 64'h0);
        check("mr_valid", 64'(cmd_valid), 64'h0);
        check("mr_errcode", 64'(err_code), 64'h0);
        check("mr_busy", 64'(busy), 64'h0);
        idle(2);
        check("mr_no_err", 64'(err_seen), 64'(e0));
        sys_rst_n = 1'b1;
        idle(1);
        // csum = 03^01^7E = 7C
        send(8'hAA); send(8'h03); send(8'h01); send(8'h7E); send(8'h7C);
        check("mr_next_valid", 64'(cmd_valid), 64'h1);
        check("mr_next_code", 64'(cmd_code), 64'h03);
        check("mr_next_payload", cmd_payload, 64'h7E);

        // Stalled frame
        idle(1);
        send(8'hAA); send(8'h01);
        e0 = err_seen;
`ifdef UART_CMD_TIMEOUT_EN
        idle(TC - 1);
        check("tmo_not_early", 64'(err_seen), 64'(e0));
        check("tmo_busy_before", 64'(busy), 64'h1);
        idle(1);
        check("tmo_err", 64'(cmd_err), 64'h1);
        check("tmo_code", 64'(err_code), 64'h3);
        check("tmo_busy_after", 64'(busy), 64'h0);
`else
        idle(200);
        check("stall_busy", 64'(busy), 64'h1);
        check("stall_no_err", 64'(err_seen), 64'(e0));
        // csum = 01^00 = 01
        send(8'h00); send(8'h01);
        check("stall_resume_valid", 64'(cmd_valid), 64'h1);
        check("stall_resume_code", 64'(cmd_code), 64'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
